// File: rtl/cpu_fetch_queue.sv
// Sequential instruction prefetcher feeding decode from a small PC/word FIFO.
// One bus fetch in flight at most; jumps flush the FIFO and squash an in-flight fetch.
module cpu_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_jump,
  input  logic [31:0] i_jump_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_instruction
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0]    state;
  logic [31:0]   fetch_pc;
  logic [31:0]   bus_address;
  logic          bus_request;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];

  logic [31:0] jump_target;
  logic        full;
  logic        push;
  logic        pop;

  always_comb begin
    jump_target = i_jump_pc & 32'hFFFF_FFFC;
    full        = (count == FULL_COUNT);
    push        = (state == WAIT) && i_bus_ready && !i_jump;
    pop         = (count != '0) && i_ready && !i_jump;
  end

  // The address register only moves while the request is low, so the bus
  // always sees a stable address for the whole transaction.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      bus_request <= 1'b0;
      bus_address <= RESET_PC;
      fetch_pc    <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (i_jump) begin
            fetch_pc    <= jump_target;
            bus_address <= jump_target;
          end else if (!full) begin
            bus_request <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (i_bus_ready) begin
            bus_request <= 1'b0;
            state       <= IDLE;
            if (i_jump) begin
              fetch_pc    <= jump_target;
              bus_address <= jump_target;
            end else begin
              fetch_pc    <= fetch_pc + 32'd4;
              bus_address <= fetch_pc + 32'd4;
            end
          end else if (i_jump) begin
            fetch_pc <= jump_target;
            state    <= DISCARD;
          end
        end
        DISCARD: begin
          if (i_jump) begin
            fetch_pc <= jump_target;
          end
          if (i_bus_ready) begin
            bus_request <= 1'b0;
            state       <= IDLE;
            bus_address <= i_jump ? jump_target : fetch_pc;
          end
        end
        default: begin
          state       <= IDLE;
          bus_request <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (i_jump) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the head outputs read zero out of reset.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_instr[i] <= '0;
      end
    end else if (push) begin
      mem_pc[wr_ptr]    <= fetch_pc;
      mem_instr[wr_ptr] <= i_bus_rdata;
    end
  end

  assign o_bus_request = bus_request;
  assign o_bus_address = bus_address;
  assign o_valid       = (count != '0);
  assign o_pc          = mem_pc[rd_ptr];
  assign o_instruction = mem_instr[rd_ptr];

endmodule
